load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage between instruction_compute and the data-memory bus.
- Accepts one load or store per handshake and generates byte strobes and lane-replicated write data for the bus.
- Waits on the bus ready/response handshake, then returns load data right-justified and zero-filled; instruction_compute applies the sign/zero extension.
- Its busy output is the pipeline stall source for the memory stage.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- NUM_LANES, XLEN/8, byte lanes per bus word.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  request present.
- op_ready  output  1  unit can accept a request this cycle.
- op_is_store  input  1  1=store, 0=load.
- op_addr  input  XLEN  byte address (effective address from the compute stage).
- op_width  input  mem_width_t  write_byte / write_halfword / write_word.
- op_wdata  input  XLEN  store data, right-justified.
- result_valid  output  1  one-cycle completion pulse.
- result_misaligned  output  1  completed op was misaligned (no bus access made).
- load_val  output  XLEN  load data, right-justified, upper bits zero.
- busy  output  1  state != IDLE.
- bus_req_valid  output  1  bus request.
- bus_req_ready  input  1  bus accepts the request.
- bus_we  output  1  write enable.
- bus_addr  output  XLEN  word-aligned address {addr[31:2],2'b00}.
- bus_wstrb  output  NUM_LANES  byte strobes.
- bus_wdata  output  XLEN  lane-replicated store data.
- bus_resp_valid  input  1  response or write acknowledge.
- bus_rdata  input  XLEN  read word.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; op_ready=1; result_valid=0; result_misaligned=0; load_val=0; busy=0; bus_req_valid=0; bus_we=0; bus_addr=0; bus_wstrb=0; bus_wdata=0. All captured registers clear.
- FSM states: IDLE, REQ, RESP, DONE, FAULT.
- Handshakes:
  - op_ready = (state==IDLE).
  - Accept when op_valid && op_ready: capture is_store, addr, width, wdata.
  - op_* are ignored when op_ready=0.
- Misalignment on accept: half with addr[0]=1, or word with addr[1:0]!=0.
- IDLE:
  - Misaligned accept -> FAULT.
  - Aligned accept -> REQ.
  - Otherwise stay in IDLE.
- FAULT (one cycle): result_valid=1, result_misaligned=1, load_val=0, no bus activity; -> IDLE.
- REQ:
  - bus_req_valid=1; bus_addr, bus_we, bus_wstrb, bus_wdata are driven from the captured registers and held stable until bus_req_ready.
  - bus_req_ready=1 -> RESP. Zero-wait: REQ lasts exactly one cycle.
- Strobes (off = addr[1:0]):
  - byte: 4'b0001<<off.
  - half: 4'b0011<<off.
  - word: 4'b1111.
  - Loads drive the same strobes, with bus_we=0.
- Write data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- RESP:
  - bus_req_valid=0. Wait for bus_resp_valid; it is sampled only in RESP, earliest the cycle after the request handshake.
  - On response:
    - Loads register load_val = (bus_rdata >> 8*off) masked to 8/16/32 bits.
    - Stores set load_val=0.
  - -> DONE.
- DONE (one cycle): result_valid=1, result_misaligned=0, load_val held; -> IDLE.
- load_val holds its last value until the next completion.
- Latency: an aligned op with zero-wait bus gives accept at cycle 0, REQ at 1, RESP at 2, result_valid at 3. The next accept is possible at cycle 4.
- bus_resp_valid outside RESP is ignored (spurious).
- bus_req_ready outside REQ is ignored.
- Reset mid-operation aborts to IDLE immediately. A response for the aborted op that arrives after reset deassertion is ignored, because state is not RESP.
- busy=1 in REQ, RESP, DONE and FAULT.

Decomposition:
- Package:
  - Reuse the existing width enum (write_byte/write_halfword/write_word) as mem_width_t.
  - Add lsu_state_t (IDLE, REQ, RESP, DONE, FAULT).
  - Add a `LANE_OFF(addr)` helper constant/macro to isa_constants.
- Sub-module lsu_lane_align: purely combinational.
  - Inputs: off, width, wdata, rdata.
  - Outputs: wstrb, replicated wdata, misaligned flag, extracted load data.
  - Keeps all lane arithmetic out of the FSM.

Test Plan:
- Store word, addr 0x100, wdata 0xDEADBEEF, ready/resp immediate -> bus_addr 0x100, wstrb 4'hF, wdata 0xDEADBEEF, bus_we=1; result_valid at cycle 3, load_val=0.
- Store byte, addr 0x203, wdata 0x000000A5 -> bus_addr 0x200, wstrb 4'b1000, wdata 0xA5A5A5A5.
- Load half, addr 0x302, rdata 0x8001_1234, resp after 3 wait cycles -> wstrb 4'b1100, bus_we=0; load_val 0x0000_8001 with result_valid exactly one cycle after resp.
- Load word at addr 0x101 -> no bus_req_valid; next cycle result_valid=1, result_misaligned=1, load_val=0; op_ready back at the following cycle.
- bus_req_ready held low 5 cycles -> bus_addr/wstrb/wdata stable and op_ready=0 throughout; spurious bus_resp_valid pulse in IDLE -> no result_valid.
- reset_n pulsed low while in RESP -> all outputs at reset values within the same cycle; subsequent bus_resp_valid ignored; a new load at 0x0 completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit: access widths, FSM states, lane offset.
package load_store_unit_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_LANES = XLEN / 8;

  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } mem_width_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } lsu_state_t;

  // Byte lane within the bus word addressed by a byte address.
  function automatic logic [1:0] lane_off(input logic [XLEN-1:0] addr);
    return addr[1:0];
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/result handshake with the compute stage plus the data-memory bus, as one bundle.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic                 op_valid;
  logic                 op_ready;
  logic                 op_is_store;
  logic [XLEN-1:0]      op_addr;
  mem_width_t           op_width;
  logic [XLEN-1:0]      op_wdata;

  logic                 result_valid;
  logic                 result_misaligned;
  logic [XLEN-1:0]      load_val;

  logic                 bus_req_valid;
  logic                 bus_req_ready;
  logic                 bus_we;
  logic [XLEN-1:0]      bus_addr;
  logic [NUM_LANES-1:0] bus_wstrb;
  logic [XLEN-1:0]      bus_wdata;
  logic                 bus_resp_valid;
  logic [XLEN-1:0]      bus_rdata;

  // Environment side: compute stage issuing ops and the memory answering the bus.
  modport master (
    output op_valid, op_is_store, op_addr, op_width, op_wdata,
    output bus_req_ready, bus_resp_valid, bus_rdata,
    input  op_ready, result_valid, result_misaligned, load_val,
    input  bus_req_valid, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

  // Load/store unit side.
  modport slave (
    input  op_valid, op_is_store, op_addr, op_width, op_wdata,
    input  bus_req_ready, bus_resp_valid, bus_rdata,
    output op_ready, result_valid, result_misaligned, load_val,
    output bus_req_valid, bus_we, bus_addr, bus_wstrb, bus_wdata
  );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane logic: byte strobes, store-data replication, alignment check, load extraction.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]           off,
  input  mem_width_t           width,
  input  logic [XLEN-1:0]      wdata,
  input  logic [XLEN-1:0]      rdata,
  output logic [NUM_LANES-1:0] wstrb,
  output logic [XLEN-1:0]      wdata_rep,
  output logic                 misaligned,
  output logic [XLEN-1:0]      rdata_ext
);

  logic [XLEN-1:0] rdata_shift;

  assign rdata_shift = rdata >> {off, 3'b000};

  always_comb begin
    wstrb      = '0;
    wdata_rep  = '0;
    misaligned = 1'b0;
    rdata_ext  = '0;
    case (width)
      write_byte: begin
        wstrb     = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h0, rdata_shift[7:0]};
      end
      write_halfword: begin
        wstrb      = 4'b0011 << off;
        wdata_rep  = {2{wdata[15:0]}};
        misaligned = off[0];
        rdata_ext  = {16'h0, rdata_shift[15:0]};
      end
      write_word: begin
        wstrb      = 4'b1111;
        wdata_rep  = wdata;
        misaligned = (off != 2'b00);
        rdata_ext  = rdata_shift;
      end
      // Unencoded width: refuse it as a fault rather than touch memory.
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per handshake, bus request/response, right-justified load data.
//
//   state | meaning
//   IDLE  | op_ready high, waiting for a request
//   REQ   | bus_req_valid high, waiting for bus_req_ready
//   RESP  | waiting for bus_resp_valid
//   DONE  | one-cycle result pulse for a completed bus access
//   FAULT | one-cycle result pulse for a misaligned op, no bus access
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  load_store_unit_if.slave lsu,
  output logic             busy
);

  lsu_state_t           state;
  logic                 cap_is_store;
  logic [XLEN-1:0]      cap_addr;
  mem_width_t           cap_width;

  logic                 in_idle;
  logic                 accept;
  logic [1:0]           sel_off;
  mem_width_t           sel_width;
  logic [NUM_LANES-1:0] wstrb;
  logic [XLEN-1:0]      wdata_rep;
  logic [XLEN-1:0]      rdata_ext;
  logic                 misaligned;

  assign in_idle = (state == IDLE);
  assign accept  = lsu.op_valid && in_idle;

  // The lane block sees the live request while idle and the captured op afterwards,
  // so one instance serves both the accept decision and the load extraction.
  assign sel_off   = in_idle ? lane_off(lsu.op_addr) : lane_off(cap_addr);
  assign sel_width = in_idle ? lsu.op_width : cap_width;

  lsu_lane_align u_lane_align (
    .off        (sel_off),
    .width      (sel_width),
    .wdata      (lsu.op_wdata),
    .rdata      (lsu.bus_rdata),
    .wstrb      (wstrb),
    .wdata_rep  (wdata_rep),
    .misaligned (misaligned),
    .rdata_ext  (rdata_ext)
  );

  assign lsu.op_ready = in_idle;
  assign busy         = !in_idle;
  assign lsu.bus_addr = {cap_addr[XLEN-1:2], 2'b00};
  assign lsu.bus_we   = cap_is_store;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      cap_is_store          <= 1'b0;
      cap_addr              <= '0;
      cap_width             <= write_byte;
      lsu.bus_req_valid     <= 1'b0;
      lsu.bus_wstrb         <= '0;
      lsu.bus_wdata         <= '0;
      lsu.result_valid      <= 1'b0;
      lsu.result_misaligned <= 1'b0;
      lsu.load_val          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cap_is_store <= lsu.op_is_store;
            cap_addr     <= lsu.op_addr;
            cap_width    <= lsu.op_width;
            if (misaligned) begin
              state                 <= FAULT;
              lsu.result_valid      <= 1'b1;
              lsu.result_misaligned <= 1'b1;
              lsu.load_val          <= '0;
            end else begin
              state             <= REQ;
              lsu.bus_req_valid <= 1'b1;
              lsu.bus_wstrb     <= wstrb;
              lsu.bus_wdata     <= wdata_rep;
            end
          end
        end
        REQ: begin
          if (lsu.bus_req_ready) begin
            lsu.bus_req_valid <= 1'b0;
            state             <= RESP;
          end
        end
        RESP: begin
          if (lsu.bus_resp_valid) begin
            lsu.load_val          <= cap_is_store ? '0 : rdata_ext;
            lsu.result_valid      <= 1'b1;
            lsu.result_misaligned <= 1'b0;
            state                 <= DONE;
          end
        end
        DONE, FAULT: begin
          lsu.result_valid      <= 1'b0;
          lsu.result_misaligned <= 1'b0;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: byte-level memory model predicts results and bus requests; a bus responder and a result monitor check.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  typedef struct {
    bit          mis;
    logic [31:0] val;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  strb;
    logic [31:0] data;
  } bexp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  int   cyc = 0;

  load_store_unit_if bus_if();

  load_store_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .lsu     (bus_if),
    .busy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t  exp_q[$];
  bexp_t bus_q[$];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] last_load = 32'h0;

  int          req_wait  = 0;
  int          resp_wait = 0;
  bit          spur      = 1'b0;
  bit          pend      = 1'b0;
  int          pcnt      = 0;
  logic [31:0] prdata    = 32'h0;
  int          resp_cyc  = -10;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic int size_of(input mem_width_t w);
    case (w)
      write_byte:     return 1;
      write_halfword: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_mem.exists(a)) return ref_mem[a];
    w = init_word({a[31:2], 2'b00}) >> (8 * a[1:0]);
    return w[7:0];
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int sz);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | ({24'h0, ref_byte(a + i)} << (8 * i));
    return v;
  endfunction

  task automatic ref_write(input logic [31:0] a, input int sz, input logic [31:0] wd);
    logic [31:0] t;
    for (int i = 0; i < sz; i++) begin
      t = wd >> (8 * i);
      ref_mem[a + i] = t[7:0];
    end
  endtask

  task automatic preset_word(input logic [31:0] a, input logic [31:0] v);
    bus_mem[a >> 2] = v;
    ref_write({a[31:2], 2'b00}, 4, v);
  endtask

  task automatic issue(input bit st, input logic [31:0] addr, input mem_width_t w,
                       input logic [31:0] wd, input int rw, input int pw);
    int          sz;
    int          g;
    exp_t        e;
    bexp_t       b;
    logic [31:0] t;
    g = 0;
    while (!bus_if.op_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("op_ready_idle", {31'h0, bus_if.op_ready}, 32'h1);
    sz        = size_of(w);
    req_wait  = rw;
    resp_wait = pw;
    e.mis = (addr % sz) != 0;
    e.due = cyc + (e.mis ? 1 : 3 + rw + pw);
    e.val = (e.mis || st) ? 32'h0 : ref_read(addr, sz);
    if (!e.mis) begin
      b.addr = addr & 32'hFFFF_FFFC;
      b.we   = st;
      b.strb = 4'h0;
      b.data = 32'h0;
      for (int i = 0; i < sz; i++) b.strb[(addr + i) % 4] = 1'b1;
      for (int l = 0; l < 4; l++) begin
        t = wd >> (8 * (l % sz));
        b.data[8*l +: 8] = t[7:0];
      end
      bus_q.push_back(b);
      if (st) ref_write(addr, sz, wd);
    end
    exp_q.push_back(e);
    bus_if.op_is_store = st;
    bus_if.op_addr     = addr;
    bus_if.op_width    = w;
    bus_if.op_wdata    = wd;
    bus_if.op_valid    = 1'b1;
    @(negedge clk);
    // Garbage request while busy must be ignored.
    chk("op_ready_busy", {31'h0, bus_if.op_ready}, 32'h0);
    bus_if.op_is_store = $urandom_range(0, 1);
    bus_if.op_addr     = $urandom;
    bus_if.op_wdata    = $urandom;
    @(negedge clk);
    bus_if.op_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int g = 0;
    if (exp_q.size() != 0) begin
      while (exp_q.size() != 0 && g < budget) begin
        @(negedge clk);
        #1;
        g++;
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        $display("FAIL result_timeout: %0d results still outstanding after %0d cycles", exp_q.size(), budget);
        exp_q.delete();
        bus_q.delete();
      end
      @(negedge clk);
    end
    chk("op_ready_after_result", {31'h0, bus_if.op_ready}, 32'h1);
  endtask

  // Result monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus_if.result_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_result: result_valid with nothing outstanding (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            chk("result_misaligned", {31'h0, bus_if.result_misaligned}, {31'h0, e.mis});
            chk("load_val", bus_if.load_val, e.val);
            chk("result_cycle", cyc, e.due);
            if (!e.mis) chk("resp_to_result", cyc, resp_cyc + 1);
            last_load = e.val;
          end
        end else begin
          chk("load_val_hold", bus_if.load_val, last_load);
        end
      end
    end
  end

  // Bus responder with programmable ready/response wait states
  initial begin
    bexp_t       b;
    bit          in_req = 1'b0;
    int          wcnt   = 0;
    logic [31:0] h_addr, h_data, cur;
    logic [3:0]  h_strb;
    bus_if.bus_req_ready  = 1'b0;
    bus_if.bus_resp_valid = 1'b0;
    bus_if.bus_rdata      = 32'h0;
    forever begin
      @(negedge clk);
      bus_if.bus_resp_valid = 1'b0;
      if (spur) begin
        bus_if.bus_resp_valid = 1'b1;
        bus_if.bus_rdata      = $urandom;
        spur = 1'b0;
      end
      if (pend) begin
        if (pcnt == 0) begin
          bus_if.bus_resp_valid = 1'b1;
          bus_if.bus_rdata      = prdata;
          pend     = 1'b0;
          resp_cyc = cyc;
        end else pcnt--;
      end
      if (!reset_n || !bus_if.bus_req_valid) begin
        in_req = 1'b0;
        bus_if.bus_req_ready = 1'b0;
      end else begin
        if (!in_req) begin
          in_req = 1'b1;
          wcnt   = 0;
          if (bus_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_bus_req: addr 0x%08h (cycle %0d)", bus_if.bus_addr, cyc);
          end else begin
            b = bus_q.pop_front();
            chk("bus_addr", bus_if.bus_addr, b.addr);
            chk("bus_we", {31'h0, bus_if.bus_we}, {31'h0, b.we});
            chk("bus_wstrb", {28'h0, bus_if.bus_wstrb}, {28'h0, b.strb});
            if (b.we) chk("bus_wdata", bus_if.bus_wdata, b.data);
          end
          h_addr = bus_if.bus_addr;
          h_strb = bus_if.bus_wstrb;
          h_data = bus_if.bus_wdata;
        end else begin
          chk("hold_addr", bus_if.bus_addr, h_addr);
          chk("hold_wstrb", {28'h0, bus_if.bus_wstrb}, {28'h0, h_strb});
          chk("hold_wdata", bus_if.bus_wdata, h_data);
          chk("hold_op_ready", {31'h0, bus_if.op_ready}, 32'h0);
        end
        if (wcnt >= req_wait) begin
          bus_if.bus_req_ready = 1'b1;
          cur = bus_mem.exists(bus_if.bus_addr >> 2) ? bus_mem[bus_if.bus_addr >> 2]
                                                      : init_word(bus_if.bus_addr);
          if (bus_if.bus_we) begin
            for (int l = 0; l < 4; l++)
              if (bus_if.bus_wstrb[l]) cur[8*l +: 8] = bus_if.bus_wdata[8*l +: 8];
            bus_mem[bus_if.bus_addr >> 2] = cur;
            prdata = $urandom;
          end else begin
            prdata = cur;
          end
          pend = 1'b1;
          pcnt = resp_wait;
        end else begin
          bus_if.bus_req_ready = 1'b0;
          wcnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    bit          st;
    int          ws;
    mem_width_t  w;
    logic [31:0] a;
    reset_n            = 1'b1;
    bus_if.op_valid    = 1'b0;
    bus_if.op_is_store = 1'b0;
    bus_if.op_addr     = 32'h0;
    bus_if.op_width    = write_byte;
    bus_if.op_wdata    = 32'h0;
    #2 reset_n = 1'b0;
    #2;
    chk("rst_op_ready", {31'h0, bus_if.op_ready}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_result_valid", {31'h0, bus_if.result_valid}, 32'h0);
    chk("rst_bus_req_valid", {31'h0, bus_if.bus_req_valid}, 32'h0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
    chk("rst_load_val", bus_if.load_val, 32'h0);
    @(negedge clk);
    @(negedge clk);
    #3 reset_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 32'h100, write_word, 32'hDEADBEEF, 0, 0);
    wait_done(40);
    issue(1'b1, 32'h203, write_byte, 32'h000000A5, 0, 0);
    wait_done(40);
    preset_word(32'h300, 32'h8001_1234);
    issue(1'b0, 32'h302, write_halfword, 32'h0, 0, 3);
    wait_done(40);
    issue(1'b0, 32'h101, write_word, 32'h0, 0, 0);
    wait_done(40);
    issue(1'b1, 32'h180, write_word, 32'h1234_5678, 5, 0);
    wait_done(40);

    spur = 1'b1;
    repeat (4) @(negedge clk);

    // Reset while the load sits in RESP; its late response must be ignored.
    issue(1'b0, 32'h40, write_word, 32'h0, 0, 5);
    chk("in_resp_busy", {31'h0, busy}, 32'h1);
    chk("in_resp_req_low", {31'h0, bus_if.bus_req_valid}, 32'h0);
    #3 reset_n = 1'b0;
    exp_q.delete();
    last_load = 32'h0;
    #1;
    chk("abort_op_ready", {31'h0, bus_if.op_ready}, 32'h1);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_result_valid", {31'h0, bus_if.result_valid}, 32'h0);
    chk("abort_result_mis", {31'h0, bus_if.result_misaligned}, 32'h0);
    chk("abort_load_val", bus_if.load_val, 32'h0);
    chk("abort_req_valid", {31'h0, bus_if.bus_req_valid}, 32'h0);
    chk("abort_bus_we", {31'h0, bus_if.bus_we}, 32'h0);
    chk("abort_bus_addr", bus_if.bus_addr, 32'h0);
    chk("abort_bus_wstrb", {28'h0, bus_if.bus_wstrb}, 32'h0);
    chk("abort_bus_wdata", bus_if.bus_wdata, 32'h0);
    @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (8) @(negedge clk);
    issue(1'b0, 32'h0, write_word, 32'h0, 0, 0);
    wait_done(40);

    for (int n = 0; n < 60; n++) begin
      st = $urandom_range(0, 1);
      ws = $urandom_range(0, 2);
      w  = (ws == 0) ? write_byte : (ws == 1) ? write_halfword : write_word;
      a  = 32'h800 + $urandom_range(0, 63);
      issue(st, a, w, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
      wait_done(40);
    end

    repeat (4) @(negedge clk);
    chk("results_drained", exp_q.size(), 32'h0);
    chk("bus_reqs_drained", bus_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
